gauss_noise_ctrl: RTL

Sequencer for the 12-bit Gaussian LFSR noise source used in simulation and self-test data paths. On each start command it reseeds the generator and waits a programmable warm-up. It then streams a programmed number of 128-bit beats to a downstream AXI4-Stream consumer, applying a per-run arithmetic attenuation to every sample. It sits between the free-running generator (`sim_data`/`rst_i`) and whatever consumes test noise, such as the trigger or beamforming inputs.

---
 rtl/gauss_noise_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/gauss_noise_ctrl.sv
// gauss_noise_ctrl
//   Sequencer for the 12-bit Gaussian LFSR noise source. A start command
//   reseeds the generator, waits a programmable warm-up, and then streams
//   nbeats 128-bit beats over AXI4-Stream. Every 12-bit lane sample is
//   arithmetically right-shifted by a per-run attenuation.
//
// Ports
//   clk, rst_i             : clock, synchronous active-high reset
//   start_i, abort_i       : run request (IDLE only) / early termination
//   nbeats_i, warmup_i,
//   shift_i                : run parameters, latched at start
//   gen_rst_o, gen_data_i  : generator reset / generator sim_data
//   m_tdata, m_tvalid,
//   m_tready, m_tlast      : AXI4-Stream master
//   busy_o, done_o,
//   aborted_o              : status (busy, end-of-run pulse, sticky abort)
//   drop_cnt_o             : stalled STREAM cycles (discarded generator words)
//
// Build option
//   GAUSS_NOISE_CTRL_DROPCNT_EN : when defined, builds the saturating drop
//   counter; otherwise drop_cnt_o is tied to zero.
module gauss_noise_ctrl #(
  parameter int MAXBEATS_W = 16,
  parameter int WARMUP_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [MAXBEATS_W-1:0] nbeats_i,
  input  logic [WARMUP_W-1:0]   warmup_i,
  input  logic [2:0]            shift_i,
  output logic                  gen_rst_o,
  input  logic [127:0]          gen_data_i,
  output logic [127:0]          m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic [15:0]           drop_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RESEED, S_WARMUP, S_STREAM, S_DONE
  } state_t;

  state_t                state, state_n;
  logic                  rs_cnt, rs_n;
  logic [WARMUP_W-1:0]   wu_cnt, wu_n;
  logic [MAXBEATS_W-1:0] beats_left, bl_n;
  logic [2:0]            shift_q, sh_n;
  logic                  abort_pend, ap_n;
  logic [127:0]          td_n;
  logic                  tv_n, tl_n, ab_n;
  logic                  hs;

  logic [127:0]          scaled;
  logic signed [15:0]    lane;
  logic                  unused_hi;

  // Per-lane sign extension of the 12-bit sample followed by a flooring
  // arithmetic shift; the top nibble of each lane is don't-care.
  always_comb begin
    scaled    = '0;
    lane      = '0;
    unused_hi = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      lane = signed'({{4{gen_data_i[16*k+11]}}, gen_data_i[16*k +: 12]});
      scaled[16*k +: 16] = lane >>> shift_q;
      unused_hi = unused_hi ^ (^gen_data_i[16*k+12 +: 4]);
    end
  end

  assign hs = m_tvalid && m_tready;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= S_IDLE;
      rs_cnt     <= 1'b0;
      wu_cnt     <= '0;
      beats_left <= '0;
      shift_q    <= '0;
      abort_pend <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      aborted_o  <= 1'b0;
      gen_rst_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state      <= state_n;
      rs_cnt     <= rs_n;
      wu_cnt     <= wu_n;
      beats_left <= bl_n;
      shift_q    <= sh_n;
      abort_pend <= ap_n;
      m_tdata    <= td_n;
      m_tvalid   <= tv_n;
      m_tlast    <= tl_n;
      aborted_o  <= ab_n;
      gen_rst_o  <= (state_n == S_RESEED);
      busy_o     <= (state_n != S_IDLE);
      done_o     <= (state_n == S_DONE);
    end
  end

  // Termination is keyed solely on the registered m_tlast: it is set either
  // for the natural final beat or by an abort, so the handshake on a beat
  // with m_tlast high always ends the run.
  always_comb begin
    state_n = state;
    rs_n    = rs_cnt;
    wu_n    = wu_cnt;
    bl_n    = beats_left;
    sh_n    = shift_q;
    ap_n    = abort_pend;
    td_n    = m_tdata;
    tv_n    = m_tvalid;
    tl_n    = m_tlast;
    ab_n    = aborted_o;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_n = S_RESEED;
          rs_n    = 1'b0;
          wu_n    = warmup_i;
          bl_n    = nbeats_i;
          sh_n    = shift_i;
          ap_n    = 1'b0;
          ab_n    = 1'b0;
        end
      end
      S_RESEED: begin
        if (abort_i) begin
          state_n = S_DONE;
          ab_n    = 1'b1;
        end else if (!rs_cnt) begin
          rs_n = 1'b1;
        end else if (wu_cnt != '0) begin
          state_n = S_WARMUP;
        end else if (beats_left == '0) begin
          state_n = S_DONE;
        end else begin
          state_n = S_STREAM;
          td_n    = scaled;
          tv_n    = 1'b1;
          tl_n    = (beats_left == MAXBEATS_W'(1));
        end
      end
      S_WARMUP: begin
        if (abort_i) begin
          state_n = S_DONE;
          ab_n    = 1'b1;
        end else if (wu_cnt != WARMUP_W'(1)) begin
          wu_n = wu_cnt - 1'b1;
        end else if (beats_left == '0) begin
          state_n = S_DONE;
        end else begin
          state_n = S_STREAM;
          td_n    = scaled;
          tv_n    = 1'b1;
          tl_n    = (beats_left == MAXBEATS_W'(1));
        end
      end
      S_STREAM: begin
        if (hs && m_tlast) begin
          state_n = S_DONE;
          tv_n    = 1'b0;
          tl_n    = 1'b0;
          ab_n    = abort_pend || abort_i;
        end else if (hs) begin
          td_n = scaled;
          bl_n = beats_left - 1'b1;
          tl_n = (beats_left == MAXBEATS_W'(2)) || abort_i;
          ap_n = abort_pend || abort_i;
        end else if (abort_i) begin
          tl_n = 1'b1;
          ap_n = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

`ifdef GAUSS_NOISE_CTRL_DROPCNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      drop_cnt <= '0;
    end else if (state == S_IDLE && start_i) begin
      drop_cnt <= '0;
    end else if (state == S_STREAM && m_tvalid && !m_tready && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

endmodule
